cpu_bus_ctrl: RTL

- Downstream target of the CPU's external data bus: consumes the bus strobe, write enable, address and write data; returns read data with a one-cycle ready pulse.
- Decodes each request to one of two regions:
  - an internal I/O register window;
  - an external memory port with a req/ack handshake.
- Sits between the CPU core and board-level memory/peripherals, on the CPU clock.

---
 rtl/cpu_bus_ctrl_pkg.sv | 15 +
 rtl/cpu_bus_ioregs.sv | 59 +++++
 rtl/cpu_bus_ctrl.sv | 120 ++++++++++++
 3 files changed

// File: rtl/cpu_bus_ctrl_pkg.sv
// cpu_bus_ctrl_pkg: shared state encoding, I/O register map and status layout for cpu_bus_ctrl.
package cpu_bus_ctrl_pkg;
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_IO,
        ST_MEM_REQ
    } state_t;
    localparam logic [3:0] REG_CYCLES     = 4'd8;
    localparam logic [3:0] REG_STATUS     = 4'd9;
    localparam logic [3:0] REG_STATUS_CLR = 4'd10;
    localparam logic [31:0] DEAD_BEEF     = 32'hDEAD_BEEF;
    localparam int STAT_OVERRUN   = 0;
    localparam int STAT_TIMEOUT   = 1;
    localparam int STAT_COUNT_LSB = 16;
endpackage

// File: rtl/cpu_bus_ioregs.sv
// cpu_bus_ioregs: scratch registers, free-running cycle counter and sticky status behind a single-cycle port.
module cpu_bus_ioregs
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              access,
    input  logic              we,
    input  logic [3:0]        idx,
    input  logic [DATA_W-1:0] wdata,
    input  logic              overrun,
    input  logic              timeout,
    input  logic              done,
    output logic [DATA_W-1:0] rdata
);
    import cpu_bus_ctrl_pkg::*;

    logic [DATA_W-1:0] scratch [8];
    logic [DATA_W-1:0] cycles;
    logic [1:0]        sticky;
    logic [15:0]       txn_count;
    logic [31:0]       status_word;
    logic              wr;
    logic              clr;

    assign wr  = access && we;
    assign clr = wr && idx == REG_STATUS_CLR;

    always_comb begin
        status_word = '0;
        status_word[STAT_OVERRUN] = sticky[0];
        status_word[STAT_TIMEOUT] = sticky[1];
        status_word[STAT_COUNT_LSB +: 16] = txn_count;
    end

    // Counter, sticky flags (a same-cycle set beats a clear) and scratch writes.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) scratch[i] <= '0;
            cycles    <= '0;
            sticky    <= '0;
            txn_count <= '0;
        end else begin
            cycles    <= cycles + DATA_W'(1);
            txn_count <= txn_count + 16'(done);
            sticky[0] <= overrun | (sticky[0] & ~(clr & wdata[0]));
            sticky[1] <= timeout | (sticky[1] & ~(clr & wdata[1]));
            if (wr && !idx[3]) scratch[idx[2:0]] <= wdata;
        end
    end

    // Read mux sees register values from before this cycle's update.
    always_comb begin
        rdata = !idx[3]              ? scratch[idx[2:0]] :
                idx == REG_CYCLES    ? cycles :
                idx == REG_STATUS    ? DATA_W'(status_word) : '0;
    end
endmodule

// File: rtl/cpu_bus_ctrl.sv
// cpu_bus_ctrl: CPU bus target decoding to an I/O register window or a req/ack memory port; CPU_BUS_CTRL_TIMEOUT_EN adds an ack timeout.
module cpu_bus_ctrl
#(
    parameter int                ADDR_W         = 32,
    parameter int                DATA_W         = 32,
    parameter logic [ADDR_W-1:0] IO_BASE        = 32'hFFFF_0000,
    parameter int                TIMEOUT_CYCLES = 255
) (
    input  logic              i_cpu_clk,
    input  logic              i_rst,
    input  logic              i_bus_clk,
    input  logic              i_bus_we,
    input  logic [ADDR_W-1:0] i_bus_addr,
    input  logic [DATA_W-1:0] i_bus_data,
    output logic [DATA_W-1:0] o_bus_data,
    output logic              o_bus_data_ready,
    output logic              o_mem_req,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic              i_mem_ack,
    input  logic [DATA_W-1:0] i_mem_rdata
);
    import cpu_bus_ctrl_pkg::*;

`ifdef CPU_BUS_CTRL_TIMEOUT_EN
    localparam logic TIMEOUT_EN = 1'b1;
`else
    localparam logic TIMEOUT_EN = 1'b0;
`endif
    localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t            state;
    logic              strobe_q;
    logic              lat_we;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_data;
    logic [15:0]       wait_cnt;
    logic              strobe_edge;
    logic              start;
    logic              overrun;
    logic              timeout_hit;
    logic [DATA_W-1:0] io_rdata;

    assign strobe_edge = i_bus_clk && !strobe_q;
    assign start       = strobe_edge && state == ST_IDLE && !o_bus_data_ready;
    assign overrun     = strobe_edge && !start;
    assign timeout_hit = TIMEOUT_EN && state == ST_MEM_REQ && o_mem_req && !i_mem_ack && wait_cnt == WAIT_LAST;

    // Strobe edge detection, request latching and the IO / MEM_REQ sequencing with registered outputs.
    always_ff @(posedge i_cpu_clk) begin
        if (i_rst) begin
            state            <= ST_IDLE;
            strobe_q         <= 1'b0;
            lat_we           <= 1'b0;
            lat_addr         <= '0;
            lat_data         <= '0;
            wait_cnt         <= '0;
            o_bus_data       <= '0;
            o_bus_data_ready <= 1'b0;
            o_mem_req        <= 1'b0;
            o_mem_we         <= 1'b0;
            o_mem_addr       <= '0;
            o_mem_wdata      <= '0;
        end else begin
            strobe_q         <= i_bus_clk;
            o_bus_data_ready <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        lat_we   <= i_bus_we;
                        lat_addr <= i_bus_addr;
                        lat_data <= i_bus_data;
                        state    <= i_bus_addr[ADDR_W-1:6] == IO_BASE[ADDR_W-1:6] ? ST_IO : ST_MEM_REQ;
                    end
                end
                ST_IO: begin
                    o_bus_data_ready <= 1'b1;
                    o_bus_data       <= lat_we ? '0 : io_rdata;
                    state            <= ST_IDLE;
                end
                ST_MEM_REQ: begin
                    if (!o_mem_req) begin
                        o_mem_req   <= 1'b1;
                        o_mem_we    <= lat_we;
                        o_mem_addr  <= lat_addr;
                        o_mem_wdata <= lat_data;
                        wait_cnt    <= '0;
                    end else if (i_mem_ack) begin
                        o_mem_req        <= 1'b0;
                        o_bus_data_ready <= 1'b1;
                        o_bus_data       <= lat_we ? '0 : i_mem_rdata;
                        state            <= ST_IDLE;
                    end else if (timeout_hit) begin
                        o_mem_req        <= 1'b0;
                        o_bus_data_ready <= 1'b1;
                        o_bus_data       <= DATA_W'(DEAD_BEEF);
                        state            <= ST_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    cpu_bus_ioregs #(.DATA_W(DATA_W)) u_ioregs (
        .clk     (i_cpu_clk),
        .rst     (i_rst),
        .access  (state == ST_IO),
        .we      (lat_we),
        .idx     (lat_addr[5:2]),
        .wdata   (lat_data),
        .overrun (overrun),
        .timeout (timeout_hit),
        .done    (o_bus_data_ready),
        .rdata   (io_rdata)
    );
endmodule
